// File: rtl/branch_resolve_ctrl.sv
// rtl/branch_resolve_ctrl.sv - single-branch resolve/redirect/flush/trap sequencer
// Optional counters enabled by defining BRANCH_STATS_EN.
module branch_resolve_ctrl #(
  parameter int XLEN          = 32,
  parameter bit RESET_PC_ZERO = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            br_valid,
  output logic            br_ready,
  input  logic [XLEN-1:0] br_pc,
  input  logic [XLEN-1:0] br_rs1_val,
  input  logic [XLEN-1:0] br_rs2_val,
  input  logic [12:0]     br_imm,
  input  logic [2:0]      br_control,
  input  logic            br_pred_taken,
  output logic            resolve_valid,
  output logic            resolve_taken,
  output logic            resolve_mispredict,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ready,
  output logic            flush,
  output logic            trap_valid,
  output logic [XLEN-1:0] trap_pc,
  input  logic            trap_ack
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_taken,
  output logic [31:0]     stat_mispredicts
`endif
);

  typedef enum logic [2:0] {IDLE, EVAL, REDIRECT, FLUSH, TRAP, DONE} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc_q, rs1_q, rs2_q, redir_pc_q;
  logic [12:0]     imm_q;
  logic [2:0]      ctrl_q;
  logic            pred_q;
  logic            accept, taken, misaligned, mispredict;
  logic [XLEN-1:0] target, fallthrough;

  assign accept = br_valid & (state == IDLE);

  always_comb begin
    target      = pc_q + {{(XLEN-13){imm_q[12]}}, imm_q};
    fallthrough = pc_q + XLEN'(4);
    case (ctrl_q)
      3'd1:    taken = (rs1_q != rs2_q);
      3'd2:    taken = ($signed(rs1_q) <  $signed(rs2_q));
      3'd3:    taken = ($signed(rs1_q) >= $signed(rs2_q));
      3'd4:    taken = (rs1_q <  rs2_q);
      3'd5:    taken = (rs1_q >= rs2_q);
      default: taken = (rs1_q == rs2_q);
    endcase
    // a misaligned taken target traps instead of redirecting, so it is never a mispredict
    misaligned = taken & target[1];
    mispredict = ~misaligned & (taken != pred_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept) state_nxt = EVAL;
      EVAL: begin
        if (misaligned)      state_nxt = TRAP;
        else if (mispredict) state_nxt = REDIRECT;
        else                 state_nxt = DONE;
      end
      REDIRECT: if (redirect_ready) state_nxt = FLUSH;
      FLUSH:    state_nxt = IDLE;
      TRAP:     if (trap_ack) state_nxt = IDLE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    br_ready       = (state == IDLE);
    redirect_valid = (state == REDIRECT);
    flush          = (state == FLUSH);
    trap_valid     = (state == TRAP);
    redirect_pc    = (state == REDIRECT) ? redir_pc_q : '0;
    trap_pc        = (state == TRAP)     ? pc_q       : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resolve_valid      <= 1'b0;
      resolve_taken      <= 1'b0;
      resolve_mispredict <= 1'b0;
    end else begin
      resolve_valid      <= (state == EVAL);
      resolve_taken      <= (state == EVAL) & taken;
      resolve_mispredict <= (state == EVAL) & mispredict;
    end
  end

  // operand/PC registers; reset clearing is optional since control state alone gates all outputs
  generate
    if (RESET_PC_ZERO) begin : g_data_rst
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pc_q <= '0; rs1_q <= '0; rs2_q <= '0; redir_pc_q <= '0;
          imm_q <= '0; ctrl_q <= '0; pred_q <= 1'b0;
        end else begin
          if (accept) begin
            pc_q <= br_pc; rs1_q <= br_rs1_val; rs2_q <= br_rs2_val;
            imm_q <= br_imm; ctrl_q <= br_control; pred_q <= br_pred_taken;
          end
          if (state == EVAL) redir_pc_q <= taken ? target : fallthrough;
        end
      end
    end else begin : g_data_norst
      always_ff @(posedge clk) begin
        if (accept) begin
          pc_q <= br_pc; rs1_q <= br_rs1_val; rs2_q <= br_rs2_val;
          imm_q <= br_imm; ctrl_q <= br_control; pred_q <= br_pred_taken;
        end
        if (state == EVAL) redir_pc_q <= taken ? target : fallthrough;
      end
    end
  endgenerate

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_taken       <= '0;
      stat_mispredicts <= '0;
    end else if (resolve_valid) begin
      stat_branches    <= stat_branches + 32'd1;
      stat_taken       <= stat_taken + {31'd0, resolve_taken};
      stat_mispredicts <= stat_mispredicts + {31'd0, resolve_mispredict};
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb/tb_branch_resolve_ctrl.sv - directed scoreboard bench for branch_resolve_ctrl
module tb_branch_resolve_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        br_valid, br_ready;
  logic [31:0] br_pc, br_rs1_val, br_rs2_val;
  logic [12:0] br_imm;
  logic [2:0]  br_control;
  logic        br_pred_taken;
  logic        resolve_valid, resolve_taken, resolve_mispredict;
  logic        redirect_valid, redirect_ready;
  logic [31:0] redirect_pc;
  logic        flush, trap_valid, trap_ack;
  logic [31:0] trap_pc;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches, stat_taken, stat_mispredicts;
`endif

  int n_vec = 0;
  int n_mis = 0;

  typedef struct packed {logic taken; logic mis;} res_t;
  res_t        exp_res[$];
  logic [31:0] exp_redir[$];
  logic [31:0] exp_trap[$];

  always #5 clk = ~clk;

  branch_resolve_ctrl #(.XLEN(32), .RESET_PC_ZERO(1)) dut (
    .clk(clk), .rst(rst),
    .br_valid(br_valid), .br_ready(br_ready), .br_pc(br_pc),
    .br_rs1_val(br_rs1_val), .br_rs2_val(br_rs2_val), .br_imm(br_imm),
    .br_control(br_control), .br_pred_taken(br_pred_taken),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .resolve_mispredict(resolve_mispredict),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready), .flush(flush),
    .trap_valid(trap_valid), .trap_pc(trap_pc), .trap_ack(trap_ack)
`ifdef BRANCH_STATS_EN
    , .stat_branches(stat_branches), .stat_taken(stat_taken),
    .stat_mispredicts(stat_mispredicts)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the resolve cycle.
  task automatic issue(input logic [2:0] c, input logic [31:0] pc, input logic [31:0] a,
                       input logic [31:0] b, input logic [12:0] imm, input logic pred);
    logic        t;
    logic [31:0] tgt, ft;
    res_t        r;
    int          k;
    case (c)
      3'd1:    t = a != b;
      3'd2:    t = $signed(a) < $signed(b);
      3'd3:    t = !($signed(a) < $signed(b));
      3'd4:    t = a < b;
      3'd5:    t = !(a < b);
      default: t = a == b;
    endcase
    tgt = pc + {{19{imm[12]}}, imm};
    ft  = pc + 32'd4;
    if (t && tgt[1]) begin
      exp_res.push_back('{taken: 1'b1, mis: 1'b0});
      exp_trap.push_back(pc);
    end else begin
      exp_res.push_back('{taken: t, mis: (t != pred)});
      if (t != pred) exp_redir.push_back(t ? tgt : ft);
    end
    k = 0;
    while (!br_ready && k < 20) begin @(negedge clk); k++; end
    check("issue_ready", {31'd0, br_ready}, 32'd1);
    br_valid = 1'b1; br_control = c; br_pc = pc; br_rs1_val = a; br_rs2_val = b;
    br_imm = imm; br_pred_taken = pred;
    @(posedge clk);
    @(negedge clk);
    br_valid = 1'b0;
    check("eval_br_ready", {31'd0, br_ready}, 32'd0);
    check("eval_no_resolve", {31'd0, resolve_valid}, 32'd0);
    @(negedge clk);
    r = exp_res.pop_front();
    check("resolve_valid", {31'd0, resolve_valid}, 32'd1);
    check("resolve_taken", {31'd0, resolve_taken}, {31'd0, r.taken});
    check("resolve_mispredict", {31'd0, resolve_mispredict}, {31'd0, r.mis});
  endtask

  task automatic expect_redirect(input int hold);
    logic [31:0] e;
    e = exp_redir.pop_front();
    for (int i = 0; i < hold; i++) begin
      check("redirect_hold_valid", {31'd0, redirect_valid}, 32'd1);
      check("redirect_hold_pc", redirect_pc, e);
      check("redirect_hold_noflush", {31'd0, flush}, 32'd0);
      @(negedge clk);
    end
    redirect_ready = 1'b1;
    check("redirect_valid", {31'd0, redirect_valid}, 32'd1);
    check("redirect_pc", redirect_pc, e);
    @(negedge clk);
    redirect_ready = 1'b0;
    check("flush_pulse", {31'd0, flush}, 32'd1);
    check("redirect_dropped", {31'd0, redirect_valid}, 32'd0);
    @(negedge clk);
    check("flush_one_cycle", {31'd0, flush}, 32'd0);
    check("idle_after_flush", {31'd0, br_ready}, 32'd1);
  endtask

  task automatic expect_trap();
    logic [31:0] e;
    e = exp_trap.pop_front();
    redirect_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("trap_valid_held", {31'd0, trap_valid}, 32'd1);
      check("trap_pc", trap_pc, e);
      check("trap_no_redirect", {31'd0, redirect_valid}, 32'd0);
      check("trap_no_flush", {31'd0, flush}, 32'd0);
      @(negedge clk);
    end
    redirect_ready = 1'b0;
    trap_ack = 1'b1;
    @(negedge clk);
    trap_ack = 1'b0;
    check("trap_cleared", {31'd0, trap_valid}, 32'd0);
    check("trap_idle_ready", {31'd0, br_ready}, 32'd1);
    check("trap_ack_no_flush", {31'd0, flush}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; br_valid = 1'b0; br_pc = '0; br_rs1_val = '0; br_rs2_val = '0;
    br_imm = '0; br_control = '0; br_pred_taken = 1'b0;
    redirect_ready = 1'b0; trap_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_br_ready", {31'd0, br_ready}, 32'd1);
    check("rst_outputs", {26'd0, resolve_valid, resolve_taken, resolve_mispredict,
                          redirect_valid, flush, trap_valid}, 32'd0);
    check("rst_redirect_pc", redirect_pc, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // BEQ taken, predicted taken: DONE path, ready again after 3 cycles
    issue(3'd0, 32'h100, 32'd5, 32'd5, 13'h010, 1'b1);
    check("beq_no_redirect", {31'd0, redirect_valid}, 32'd0);
    check("beq_no_trap", {31'd0, trap_valid}, 32'd0);
    check("beq_busy_done", {31'd0, br_ready}, 32'd0);
    @(negedge clk);
    check("beq_ready_c3", {31'd0, br_ready}, 32'd1);
    check("beq_no_flush", {31'd0, flush}, 32'd0);

    // BLT signed taken, mispredicted; fetch stalls the redirect three cycles
    issue(3'd2, 32'h200, 32'hFFFF_FFFF, 32'd1, 13'h1FF8, 1'b0);
    check("blt_redirect_pc_const", redirect_pc, 32'h1F8);
    expect_redirect(3);

    // BLTU not taken; redirect_ready raised early must not matter before REDIRECT
    redirect_ready = 1'b1;
    issue(3'd4, 32'h200, 32'hFFFF_FFFF, 32'd1, 13'h1FF8, 1'b1);
    check("bltu_redirect_pc_const", redirect_pc, 32'h204);
    expect_redirect(0);

    // BNE to misaligned target traps
    trap_ack = 1'b1;
    issue(3'd1, 32'h102, 32'd1, 32'd2, 13'h004, 1'b1);
    trap_ack = 1'b0;
    check("bne_trap_pc_const", trap_pc, 32'h102);
    expect_trap();

    // reset while a redirect is pending abandons it
    issue(3'd0, 32'h100, 32'd1, 32'd2, 13'h010, 1'b1);
    check("pre_rst_redirect", {31'd0, redirect_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_redirect", {31'd0, redirect_valid}, 32'd0);
    check("async_rst_ready", {31'd0, br_ready}, 32'd1);
    check("async_rst_resolve", {31'd0, resolve_valid}, 32'd0);
    exp_redir.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("post_rst_no_flush", {31'd0, flush}, 32'd0);
      check("post_rst_no_redirect", {31'd0, redirect_valid}, 32'd0);
      @(negedge clk);
    end

    // BGEU equal operands at top of address space: target wraps to 0x4
    issue(3'd5, 32'hFFFF_FFFC, 32'd7, 32'd7, 13'h008, 1'b0);
    check("bgeu_wrap_pc_const", redirect_pc, 32'h4);
    expect_redirect(1);
`ifdef BRANCH_STATS_EN
    check("stat_branches", stat_branches, 32'd1);
    check("stat_taken", stat_taken, 32'd1);
    check("stat_mispredicts", stat_mispredicts, 32'd1);
`endif

    // BGE not taken (-1 >= 0 false), correctly predicted; control 7 aliases BEQ
    issue(3'd3, 32'h300, 32'hFFFF_FFFF, 32'd0, 13'h020, 1'b0);
    check("bge_no_redirect", {31'd0, redirect_valid}, 32'd0);
    @(negedge clk);
    issue(3'd7, 32'h400, 32'd9, 32'd9, 13'h010, 1'b0);
    check("ctl7_redirect_pc", redirect_pc, 32'h410);
    expect_redirect(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
